// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OpPass  = 3'd0,
    OpAdd   = 3'd1,
    OpLogic = 3'd2,
    OpRor   = 3'd3,
    OpPar   = 3'd4,
    OpShl   = 3'd5,
    OpMul   = 3'd6,
    OpNop   = 3'd7
  } op_e;

  typedef enum logic {
    StIdle,
    StMul
  } state_e;

endpackage

// File: rtl/seq_mul_shiftadd.sv
// N-bit unsigned shift-add multiplier core: load captures operands, each step adds one
// partial product. product_o is the accumulator value that the current step produces.
module seq_mul_shiftadd #(
  parameter int unsigned N = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] product_o
);

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   mplier_q, mplier_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (load_i) begin
      mcand_d  = {{N{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else begin
      acc_d    = acc_q;
    end
  end

  // Next accumulator value, so the final step's sum is visible on the same edge.
  assign product_o = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered N-bit ALU with start/busy/done handshake, multi-cycle multiply and an
// accumulate mode that feeds the previous result back as operand B.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           use_acc,
  output logic [2*N-1:0] result,
  output logic           carry,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CntW = $clog2(N);

  state_e          state_q, state_d;
  logic [2*N-1:0]  result_q, result_d;
  logic            carry_q, carry_d;
  logic            done_q, done_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [N-1:0]    bv;
  logic [N:0]      sum;
  logic [2*N-1:0]  shl_src;
  logic [2*N-1:0]  alu_res;
  logic [2*N-1:0]  mul_prod;
  logic            mul_load;
  logic            mul_step;

  assign bv      = use_acc ? result_q[N-1:0] : b;
  assign sum     = {1'b0, a} + {1'b0, bv};
  assign shl_src = {{N{1'b0}}, a};

  always_comb begin
    alu_res = '0;
    case (op_e'(op))
      OpPass:  alu_res = {a, bv};
      OpAdd:   alu_res = {{(N-1){1'b0}}, sum};
      OpLogic: alu_res = {a | bv, a ^ bv};
      OpRor:   alu_res[0] = |{a, bv};
      OpPar:   alu_res[0] = (~^a) & (~^bv);
      // Full-width shift: any amount >= 2N shifts everything out.
      OpShl:   alu_res = shl_src << bv;
      OpMul:   alu_res = '0;
      OpNop:   alu_res = '0;
    endcase
  end

  assign mul_load = (state_q == StIdle) && start && (op_e'(op) == OpMul);
  assign mul_step = (state_q == StMul);

  seq_mul_shiftadd #(
    .N (N)
  ) u_mul (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (a),
    .b_i       (bv),
    .product_o (mul_prod)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (op_e'(op) == OpMul) begin
            state_d = StMul;
            cnt_d   = '0;
          end else begin
            result_d = alu_res;
            done_d   = 1'b1;
            if (op_e'(op) == OpAdd) carry_d = sum[N];
          end
        end
      end
      StMul: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          result_d = mul_prod;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign done   = done_q;
  assign busy   = (state_q == StMul);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (N=4 and N=8 instances) against an arithmetic model.
module tb_seq_alu;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic       start4 = 1'b0, use_acc4 = 1'b0;
  logic [2:0] op4 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] result4;
  logic       carry4, busy4, done4;

  logic       start8 = 1'b0, use_acc8 = 1'b0;
  logic [2:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] result8;
  logic       carry8, busy8, done8;

  seq_alu #(.N(4)) u_dut4 (
    .clock (clock), .resetn (resetn), .start (start4), .op (op4), .a (a4), .b (b4),
    .use_acc (use_acc4), .result (result4), .carry (carry4), .busy (busy4), .done (done4)
  );

  seq_alu #(.N(8)) u_dut8 (
    .clock (clock), .resetn (resetn), .start (start8), .op (op8), .a (a8), .b (b8),
    .use_acc (use_acc8), .result (result8), .carry (carry8), .busy (busy8), .done (done8)
  );

  int tests = 0;
  int fails = 0;
  int exp_res = 0;
  int exp_carry = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model(input int n, input int op, input int a, input int bv);
    int w    = 2 * n;
    int mask = (1 << w) - 1;
    case (op)
      0: return (a << n) | bv;
      1: return a + bv;
      2: return ((a | bv) << n) | (a ^ bv);
      3: return (a != 0 || bv != 0) ? 1 : 0;
      4: return ($countones(a) % 2 == 0 && $countones(bv) % 2 == 0) ? 1 : 0;
      5: return (bv >= w) ? 0 : ((a << bv) & mask);
      6: return a * bv;
      default: return 0;
    endcase
  endfunction

  task automatic do_op4(input int op, input int av, input int bin, input bit acc, input bit poke);
    int bv;
    int exp_v;
    int cycles;
    @(negedge clock);
    check("idle_done4", {31'b0, done4}, 0);
    check("idle_busy4", {31'b0, busy4}, 0);
    bv    = acc ? (exp_res & 15) : bin;
    exp_v = model(4, op, av, bv);
    start4 = 1'b1; op4 = op[2:0]; a4 = av[3:0]; b4 = bin[3:0]; use_acc4 = acc;
    @(negedge clock);
    if (op != 6) begin
      start4 = 1'b0;
      if (op == 1) exp_carry = (exp_v >> 4) & 1;
      check("op_done4", {31'b0, done4}, 1);
      check("op_busy4", {31'b0, busy4}, 0);
      check("op_result4", {24'b0, result4}, exp_v);
      check("op_carry4", {31'b0, carry4}, exp_carry);
    end else begin
      check("mul_busy4", {31'b0, busy4}, 1);
      check("mul_nodone4", {31'b0, done4}, 0);
      check("mul_hold4", {24'b0, result4}, exp_res);
      if (poke) begin
        start4 = 1'b1; op4 = 3'd0; a4 = 4'($urandom); b4 = 4'($urandom); use_acc4 = 1'b0;
      end else begin
        start4 = 1'b0;
      end
      cycles = 1;
      while (busy4 === 1'b1 && cycles < 20) begin
        @(negedge clock);
        check("done_busy_excl4", {31'b0, busy4 & done4}, 0);
        if (busy4 === 1'b1) cycles++;
      end
      start4 = 1'b0;
      check("mul_cycles4", cycles, 4);
      check("mul_done4", {31'b0, done4}, 1);
      check("mul_result4", {24'b0, result4}, exp_v);
      check("mul_carry4", {31'b0, carry4}, exp_carry);
    end
    exp_res = exp_v;
  endtask

  task automatic do_op8(input int op, input int av, input int bv);
    int exp_v;
    int cycles;
    exp_v = model(8, op, av, bv);
    @(negedge clock);
    start8 = 1'b1; op8 = op[2:0]; a8 = av[7:0]; b8 = bv[7:0]; use_acc8 = 1'b0;
    @(negedge clock);
    start8 = 1'b0;
    cycles = 0;
    if (op == 6) begin
      cycles = 1;
      while (busy8 === 1'b1 && cycles < 40) begin
        @(negedge clock);
        if (busy8 === 1'b1) cycles++;
      end
      check("mul_cycles8", cycles, 8);
    end
    check("op_done8", {31'b0, done8}, 1);
    check("op_result8", {16'b0, result8}, exp_v);
  endtask

  initial begin
    resetn = 1'b0;
    #12;
    check("rst_result4", {24'b0, result4}, 0);
    check("rst_carry4", {31'b0, carry4}, 0);
    check("rst_busy4", {31'b0, busy4}, 0);
    check("rst_done4", {31'b0, done4}, 0);
    check("rst_result8", {16'b0, result8}, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("post_rst_result4", {24'b0, result4}, 0);
    check("post_rst_done4", {31'b0, done4}, 0);

    do_op4(1, 4'hF, 4'h1, 0, 0);  // 0x10, carry 1
    do_op4(2, 4'hA, 4'h6, 0, 0);  // 0xEC, carry held
    do_op4(4, 4'h3, 4'h0, 0, 0);
    do_op4(4, 4'h3, 4'h1, 0, 0);
    do_op4(3, 4'h0, 4'h0, 0, 0);
    do_op4(6, 4'hF, 4'hD, 0, 1);  // 0xC3, start during busy ignored
    do_op4(0, 4'h0, 4'h3, 0, 0);
    do_op4(1, 4'h2, 4'h0, 1, 0);  // 3 + 2
    do_op4(5, 4'h1, 4'h0, 1, 0);  // 1 << 5
    do_op4(6, 4'h7, 4'h0, 1, 0);  // acc feeds multiplier: 7 * 0x0

    // Reset in the middle of a multiply.
    do_op4(1, 4'hF, 4'hF, 0, 0);
    @(negedge clock);
    start4 = 1'b1; op4 = 3'd6; a4 = 4'h7; b4 = 4'h5; use_acc4 = 1'b0;
    @(negedge clock);
    start4 = 1'b0;
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("midmul_rst_result4", {24'b0, result4}, 0);
    check("midmul_rst_carry4", {31'b0, carry4}, 0);
    check("midmul_rst_busy4", {31'b0, busy4}, 0);
    check("midmul_rst_done4", {31'b0, done4}, 0);
    @(negedge clock);
    resetn = 1'b1;
    exp_res = 0;
    exp_carry = 0;
    do_op4(6, 4'h3, 4'h5, 0, 0);

    for (int i = 0; i < 30; i++) begin
      do_op4(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    do_op8(6, 8'hFF, 8'hFF);
    do_op8(5, 8'h01, 16);
    do_op8(5, 8'h01, 15);
    do_op8(1, 8'hFF, 8'h01);
    check("add_carry8", {31'b0, carry8}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
